tick_timer: RTL

//  Programmable tick-driven timer. Downstream consumer of the ring-counter divider output:

---
 rtl/tick_timer_pkg.sv | 14 +
 rtl/tick_timer_downcnt.sv | 39 +++
 rtl/tick_timer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick-driven timer.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RUN     = 2'd2,
        S_EXPIRED = 2'd3
    } t_timer_state;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_timer_downcnt.sv
// Loadable down-counter; load has priority over decrement, never wraps below zero.
module tick_timer_downcnt #(
    parameter int W = 8
) (
    input  logic         ck_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o,
    output logic         is_one_o,
    output logic         is_zero_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i && (value_q != '0)) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o   = value_q;
    assign is_one_o  = (value_q == W'(1));
    assign is_zero_o = (value_q == '0);

endmodule

// File: rtl/tick_timer.sv
// Programmable tick-driven timer: counts divider ticks down from a loaded value and
// raises a sticky IRQ at terminal count, in one-shot or periodic mode.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int C_CNT_WIDTH = 8
) (
    input  logic                   ck_i,
    input  logic                   rst_i,
    input  logic                   tick_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [C_CNT_WIDTH-1:0] load_val_i,
    input  logic                   load_mode_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   irq_ack_i,
    output logic                   irq_o,
    output logic                   busy_o,
    output logic [C_CNT_WIDTH-1:0] count_o
);

    t_timer_state           state_q, state_d;
    logic [C_CNT_WIDTH-1:0] reload_q, reload_d;
    logic                   mode_q, mode_d;
    logic                   irq_q, irq_d;
    logic                   busy_q, load_ready_q;

    logic                   cnt_load;
    logic [C_CNT_WIDTH-1:0] cnt_load_val;
    logic                   cnt_dec;
    logic                   cnt_is_one;
    logic                   cnt_is_zero;
    logic                   irq_set;
    logic                   load_fire;

    // Loads are only accepted outside RUN; load_ready_q mirrors that registered.
    assign load_fire = load_valid_i && load_ready_q;

    always_comb begin
        state_d      = state_q;
        reload_d     = reload_q;
        mode_d       = mode_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        irq_set      = 1'b0;

        if (load_fire) begin
            reload_d     = load_val_i;
            mode_d       = load_mode_i;
            cnt_load     = 1'b1;
            cnt_load_val = load_val_i;
            state_d      = S_ARMED;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ARMED: begin
                    if (start_i) begin
                        if (cnt_is_zero) begin
                            state_d = S_EXPIRED;
                            irq_set = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // A same-cycle tick is applied before STOP pauses the count.
                    if (tick_i) begin
                        if (cnt_is_one) begin
                            irq_set  = 1'b1;
                            cnt_load = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                cnt_load_val = reload_q;
                            end else begin
                                cnt_load_val = '0;
                                state_d      = S_EXPIRED;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                    if (stop_i && (state_d == S_RUN)) begin
                        state_d = S_ARMED;
                    end
                end
                S_EXPIRED: begin
                    if (start_i && (reload_q != '0)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = reload_q;
                        state_d      = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            reload_q     <= '0;
            mode_q       <= MODE_ONESHOT;
            irq_q        <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            reload_q     <= reload_d;
            mode_q       <= mode_d;
            irq_q        <= irq_d;
            busy_q       <= (state_d == S_RUN);
            load_ready_q <= (state_d != S_RUN);
        end
    end

    tick_timer_downcnt #(
        .W(C_CNT_WIDTH)
    ) u_downcnt (
        .ck_i      (ck_i),
        .rst_i     (rst_i),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (cnt_dec),
        .value_o   (count_o),
        .is_one_o  (cnt_is_one),
        .is_zero_o (cnt_is_zero)
    );

    assign irq_o        = irq_q;
    assign busy_o       = busy_q;
    assign load_ready_o = load_ready_q;

endmodule
